// File: rtl/ad_fifo_ctrl.sv
// ad_fifo_ctrl: occupancy tracker and add/drop sequencer for the AD-FIFO cell
// chain of the USB2 elastic buffer. Tracks bits written and read, and when the
// fill leaves the [LO_MARK, HI_MARK] window issues a single add or drop pulse,
// waits for the chain to acknowledge, then holds off before the next correction.
module ad_fifo_ctrl #(
    parameter int DEPTH   = 8,
    parameter int FILL_W  = 4,
    parameter int LO_MARK = 2,
    parameter int HI_MARK = 6,
    parameter int ACK_TO  = 8,
    parameter int HOLDOFF = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              chain_ack,
    output logic              add_left,
    output logic              drop_left,
    output logic              rd_valid,
    output logic [FILL_W-1:0] fill,
    output logic              ovf,
    output logic              unf,
    output logic              ack_err,
    output logic [7:0]        add_cnt,
    output logic [7:0]        drop_cnt
);

    localparam int TMR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRIME    = 3'd1,
        ST_TRACK    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_HOLDOFF  = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [TMR_W-1:0]    timer_r;
    logic [TMR_W-1:0]    timer_s;
    logic                ack_err_set_s;
    logic [FILL_W-1:0]   fill_r;
    logic                ovf_r;
    logic                unf_r;
    logic                ack_err_r;
    logic [7:0]          add_cnt_r;
    logic [7:0]          drop_cnt_r;
    logic                rd_valid_r;
    logic                drop_s;
    logic                add_s;
    logic [FILL_W:0]     sum_s;
    logic                sum_neg_s;
    logic                sum_over_s;

    // Correction pulses: drop has priority, so add and drop are never both high.
    always_comb begin
        drop_s = 1'b0;
        add_s  = 1'b0;
        if (state_r == ST_TRACK) begin
            if (fill_r >= FILL_W'(HI_MARK)) begin
                drop_s = 1'b1;
            end else if (fill_r <= FILL_W'(LO_MARK)) begin
                add_s = 1'b1;
            end else begin
                drop_s = 1'b0;
            end
        end else begin
            add_s = 1'b0;
        end
    end

    // Fill arithmetic one bit wider than the counter so the MSB flags a negative result.
    always_comb begin
        sum_s = {1'b0, fill_r}
              + (FILL_W+1)'(wr_en)
              - (FILL_W+1)'(rd_en & rd_valid_r)
              - (FILL_W+1)'(drop_s)
              + (FILL_W+1)'(add_s);
        sum_neg_s  = sum_s[FILL_W];
        sum_over_s = !sum_s[FILL_W] && (sum_s > (FILL_W+1)'(DEPTH));
    end

    // Sequencer next-state and shared WAIT_ACK/HOLDOFF timer.
    always_comb begin
        state_s       = state_r;
        timer_s       = timer_r;
        ack_err_set_s = 1'b0;
        if (!enable) begin
            state_s = ST_IDLE;
            timer_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_PRIME;
                    timer_s = '0;
                end
                ST_PRIME: begin
                    if (fill_r >= FILL_W'(DEPTH / 2)) begin
                        state_s = ST_TRACK;
                    end else begin
                        state_s = ST_PRIME;
                    end
                end
                ST_TRACK: begin
                    if (drop_s || add_s) begin
                        state_s = ST_WAIT_ACK;
                        timer_s = '0;
                    end else begin
                        state_s = ST_TRACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (chain_ack) begin
                        state_s = ST_HOLDOFF;
                        timer_s = '0;
                    end else if (timer_r == TMR_W'(ACK_TO - 1)) begin
                        ack_err_set_s = 1'b1;
                        state_s       = ST_HOLDOFF;
                        timer_s       = '0;
                    end else begin
                        timer_s = timer_r + 8'd1;
                    end
                end
                ST_HOLDOFF: begin
                    if (timer_r == TMR_W'(HOLDOFF - 1)) begin
                        state_s = ST_TRACK;
                        timer_s = '0;
                    end else begin
                        timer_s = timer_r + 8'd1;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    timer_s = '0;
                end
            endcase
        end
    end

    // State, timer and registered rd_valid (mirrors the next state so it tracks state_r).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            timer_r    <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            timer_r    <= timer_s;
            rd_valid_r <= (state_s == ST_TRACK) || (state_s == ST_WAIT_ACK) ||
                          (state_s == ST_HOLDOFF);
        end
    end

    // Occupancy with clamping; overflow/underflow/ack-timeout flags are sticky until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_r    <= '0;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
            ack_err_r <= 1'b0;
        end else begin
            if (!enable) begin
                fill_r <= '0;
            end else if (sum_neg_s) begin
                fill_r <= '0;
                unf_r  <= 1'b1;
            end else if (sum_over_s) begin
                fill_r <= FILL_W'(DEPTH);
                ovf_r  <= 1'b1;
            end else begin
                fill_r <= sum_s[FILL_W-1:0];
            end
            if (ack_err_set_s) begin
                ack_err_r <= 1'b1;
            end else begin
                ack_err_r <= ack_err_r;
            end
        end
    end

    // Saturating counts of issued add and drop pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            add_cnt_r  <= 8'd0;
            drop_cnt_r <= 8'd0;
        end else begin
            if (add_s && (add_cnt_r != 8'd255)) begin
                add_cnt_r <= add_cnt_r + 8'd1;
            end else begin
                add_cnt_r <= add_cnt_r;
            end
            if (drop_s && (drop_cnt_r != 8'd255)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign add_left  = add_s;
    assign drop_left = drop_s;
    assign rd_valid  = rd_valid_r;
    assign fill      = fill_r;
    assign ovf       = ovf_r;
    assign unf       = unf_r;
    assign ack_err   = ack_err_r;
    assign add_cnt   = add_cnt_r;
    assign drop_cnt  = drop_cnt_r;

endmodule
